// File: rtl/dbus_responder_pkg.sv
// Shared types for the core's memory stage.
//   m_r_t      : mem-stage result record handed on to write-back.
//   dbus_req_t : one data-bus request as captured by dbus_responder
//                (address, size, byte strobes, store data, write flag).
// The package also provides the size encodings and a helper that maps the
// illegal size code onto a word access.
package common;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  wb_addr;
    logic        wb_en;
  } m_r_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] wdata;
    logic        wr;
  } dbus_req_t;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  // The illegal size code is issued on the bus as a word access.
  function automatic logic [1:0] legal_size(input logic [1:0] s);
    return (s == SIZE_ILLEGAL) ? SIZE_WORD : s;
  endfunction

endpackage

// File: rtl/dbus_responder.sv
// dbus_responder: bridges the core's mem-stage load/store request to a
// request/addr_ok/data_ok data bus, one transaction at a time.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   flush                  pipeline flush; kills the request in flight
//   ren, wen               load / store request, held until d_data_ok
//   addr, size, strobe,    request attributes from the AGU
//   wdata
//   d_data_ok, rd          completion pulse and raw load data to mem stage
//   busy                   high whenever a transaction is in flight
//   req, wr, bsize, baddr, bus request channel
//   bwdata, bstrb
//   addr_ok, data_ok,      bus handshakes and read data
//   rdata
module dbus_responder
  import common::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [3:0]  strobe,
  input  logic [31:0] wdata,
  output logic        d_data_ok,
  output logic [31:0] rd,
  output logic        busy,
  output logic        req,
  output logic        wr,
  output logic [1:0]  bsize,
  output logic [31:0] baddr,
  output logic [31:0] bwdata,
  output logic [3:0]  bstrb,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t    state_q, state_d;
  logic      killed_q, killed_d;
  dbus_req_t lat_q, lat_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      killed_q <= 1'b0;
      lat_q    <= '0;
    end else begin
      state_q  <= state_d;
      killed_q <= killed_d;
      lat_q    <= lat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    killed_d = killed_q;
    lat_d    = lat_q;
    req      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((ren || wen) && !flush) begin
          // A read wins over a simultaneous write; reads carry no store data.
          lat_d.addr   = addr;
          lat_d.size   = legal_size(size);
          lat_d.wr     = !ren;
          lat_d.strobe = ren ? '0 : strobe;
          lat_d.wdata  = ren ? '0 : wdata;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        // The request stays up until accepted even if flushed; the flush
        // only suppresses the eventual completion pulse.
        req = 1'b1;
        if (flush) killed_d = 1'b1;
        if (addr_ok) state_d = DATA;
      end
      DATA: begin
        if (flush) killed_d = 1'b1;
        if (data_ok) begin
          state_d  = IDLE;
          killed_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        killed_d = 1'b0;
      end
    endcase
  end

  assign baddr  = lat_q.addr;
  assign bsize  = lat_q.size;
  assign wr     = lat_q.wr;
  assign bwdata = lat_q.wdata;
  assign bstrb  = lat_q.strobe;
  assign busy   = (state_q != IDLE);

  assign d_data_ok = (state_q == DATA) && data_ok && !killed_q && !flush;
  assign rd        = d_data_ok ? rdata : '0;

endmodule

// File: tb/tb_dbus_responder.sv
module tb_dbus_responder;

  logic        clk = 1'b0;
  logic        resetn, flush, ren, wen;
  logic [31:0] addr;
  logic [1:0]  size;
  logic [3:0]  strobe;
  logic [31:0] wdata;
  logic        d_data_ok;
  logic [31:0] rd;
  logic        busy, req, wr;
  logic [1:0]  bsize;
  logic [31:0] baddr, bwdata;
  logic [3:0]  bstrb;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dbus_responder dut (
    .clk(clk), .resetn(resetn), .flush(flush), .ren(ren), .wen(wen),
    .addr(addr), .size(size), .strobe(strobe), .wdata(wdata),
    .d_data_ok(d_data_ok), .rd(rd), .busy(busy), .req(req), .wr(wr),
    .bsize(bsize), .baddr(baddr), .bwdata(bwdata), .bstrb(bstrb),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  typedef struct {
    string       name;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] wdata;
    int unsigned ad_wait;
    int unsigned dd_wait;
    logic [31:0] rdata;
    logic        exp_wr;
    logic [1:0]  exp_bsize;
    logic [3:0]  exp_bstrb;
    logic [31:0] exp_bwdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; ren = 0; wen = 0; addr = '0; size = '0; strobe = '0; wdata = '0;
    addr_ok = 0; data_ok = 0; rdata = '0;
  endtask

  task automatic run_vec(input vec_t v);
    ren = v.ren; wen = v.wen; addr = v.addr; size = v.size;
    strobe = v.strobe; wdata = v.wdata; addr_ok = 0; data_ok = 0;
    @(negedge clk);
    chk({v.name, " idle busy"}, 32'(busy), 32'd0);
    chk({v.name, " idle req"}, 32'(req), 32'd0);
    step();
    for (int unsigned k = 0; k <= v.ad_wait; k++) begin
      addr_ok = (k == v.ad_wait);
      @(negedge clk);
      chk({v.name, " req"}, 32'(req), 32'd1);
      chk({v.name, " wr"}, 32'(wr), 32'(v.exp_wr));
      chk({v.name, " bsize"}, 32'(bsize), 32'(v.exp_bsize));
      chk({v.name, " baddr"}, baddr, v.addr);
      chk({v.name, " bstrb"}, 32'(bstrb), 32'(v.exp_bstrb));
      chk({v.name, " bwdata"}, bwdata, v.exp_bwdata);
      chk({v.name, " early d_data_ok"}, 32'(d_data_ok), 32'd0);
      step();
    end
    addr_ok = 0;
    for (int unsigned k = 0; k <= v.dd_wait; k++) begin
      data_ok = (k == v.dd_wait);
      rdata   = (k == v.dd_wait) ? v.rdata : 32'h1111_1111;
      @(negedge clk);
      chk({v.name, " data req"}, 32'(req), 32'd0);
      chk({v.name, " data busy"}, 32'(busy), 32'd1);
      chk({v.name, " d_data_ok"}, 32'(d_data_ok), 32'(k == v.dd_wait));
      chk({v.name, " rd"}, rd, (k == v.dd_wait) ? v.exp_rd : 32'h0);
      step();
    end
    data_ok = 0; ren = 0; wen = 0; rdata = '0;
    @(negedge clk);
    chk({v.name, " done busy"}, 32'(busy), 32'd0);
    chk({v.name, " done req"}, 32'(req), 32'd0);
    step();
  endtask

  initial begin
    //          name       ren wen addr          sz     strb     wdata         ad dd rdata         wr bsz    bstrb    bwdata        rd
    vecs[0] = '{"read",    1, 0, 32'h8000_1004, 2'b10, 4'b1111, 32'h1234_5678, 0, 0, 32'hDEAD_BEEF, 0, 2'b10, 4'b0000, 32'h0,         32'hDEAD_BEEF};
    vecs[1] = '{"store",   0, 1, 32'h0000_0010, 2'b00, 4'b0100, 32'h00AB_0000, 3, 1, 32'h0000_0000, 1, 2'b00, 4'b0100, 32'h00AB_0000, 32'h0};
    vecs[2] = '{"rw_sz11", 1, 1, 32'h0000_0020, 2'b11, 4'b1111, 32'hFFFF_FFFF, 1, 0, 32'h0000_00A5, 0, 2'b10, 4'b0000, 32'h0,         32'h0000_00A5};
    vecs[3] = '{"half_st", 0, 1, 32'h0000_0102, 2'b01, 4'b1100, 32'h5A5A_0000, 0, 2, 32'h0000_0077, 1, 2'b01, 4'b1100, 32'h5A5A_0000, 32'h0000_0077};
    vecs[4] = '{"byte_ld", 1, 0, 32'h0000_0003, 2'b00, 4'b0000, 32'h0,         2, 0, 32'h8000_0000, 0, 2'b00, 4'b0000, 32'h0,         32'h8000_0000};

    // Reset: everything zero, even with bus data handshake active.
    idle_inputs();
    resetn = 0; data_ok = 1; rdata = 32'hFFFF_FFFF;
    step(); step();
    @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst req", 32'(req), 32'd0);
    chk("rst d_data_ok", 32'(d_data_ok), 32'd0);
    chk("rst rd", rd, 32'd0);
    chk("rst baddr", baddr, 32'd0);
    chk("rst bsize", 32'(bsize), 32'd0);
    chk("rst wr", 32'(wr), 32'd0);
    chk("rst bstrb", 32'(bstrb), 32'd0);
    chk("rst bwdata", bwdata, 32'd0);
    step();
    resetn = 1; data_ok = 0; rdata = '0;
    step();

    // Flush in IDLE: nothing accepted.
    ren = 1; flush = 1; addr = 32'h0000_0050;
    step();
    ren = 0; flush = 0;
    @(negedge clk);
    chk("idle_flush busy", 32'(busy), 32'd0);
    chk("idle_flush req", 32'(req), 32'd0);
    step();

    // Flush in ADDR: req held until addr_ok, data drained, no completion.
    ren = 1; addr = 32'h0000_0040; size = 2'b10;
    step();
    flush = 1;
    @(negedge clk);
    chk("fa req0", 32'(req), 32'd1);
    step();
    flush = 0;
    @(negedge clk);
    chk("fa req1", 32'(req), 32'd1);
    chk("fa baddr", baddr, 32'h0000_0040);
    step();
    addr_ok = 1;
    @(negedge clk);
    chk("fa req2", 32'(req), 32'd1);
    step();
    addr_ok = 0; data_ok = 1; rdata = 32'h0000_CAFE;
    @(negedge clk);
    chk("fa d_data_ok", 32'(d_data_ok), 32'd0);
    chk("fa rd", rd, 32'd0);
    step();
    ren = 0; data_ok = 0;
    @(negedge clk);
    chk("fa idle busy", 32'(busy), 32'd0);
    step();

    // Flush in DATA before data_ok: suppressed completion.
    ren = 1; addr = 32'h0000_0060;
    step();
    addr_ok = 1;
    step();
    addr_ok = 0; flush = 1;
    @(negedge clk);
    chk("fd d_data_ok0", 32'(d_data_ok), 32'd0);
    step();
    flush = 0; data_ok = 1; rdata = 32'h0000_0099;
    @(negedge clk);
    chk("fd d_data_ok1", 32'(d_data_ok), 32'd0);
    step();
    ren = 0; data_ok = 0;
    @(negedge clk);
    chk("fd idle busy", 32'(busy), 32'd0);
    step();

    // Flush coincident with data_ok: combinational suppression.
    ren = 1; addr = 32'h0000_0064;
    step();
    addr_ok = 1;
    step();
    addr_ok = 0; flush = 1; data_ok = 1; rdata = 32'h0000_0055;
    @(negedge clk);
    chk("fdo d_data_ok", 32'(d_data_ok), 32'd0);
    chk("fdo rd", rd, 32'd0);
    step();
    ren = 0; flush = 0; data_ok = 0;
    @(negedge clk);
    chk("fdo idle busy", 32'(busy), 32'd0);
    step();

    // Directed vector table (also proves killed was cleared).
    foreach (vecs[i]) run_vec(vecs[i]);

    // ren held through data_ok: one request, second only from next IDLE.
    ren = 1; addr = 32'h0000_0044; size = 2'b10;
    step();
    addr_ok = 1;
    step();
    addr_ok = 0; data_ok = 1; rdata = 32'h0000_0001;
    @(negedge clk);
    chk("hold d_data_ok", 32'(d_data_ok), 32'd1);
    step();
    data_ok = 0;
    @(negedge clk);
    chk("hold idle busy", 32'(busy), 32'd0);
    chk("hold idle req", 32'(req), 32'd0);
    step();
    @(negedge clk);
    chk("hold second req", 32'(req), 32'd1);
    step();
    ren = 0;
    @(negedge clk);
    chk("hold single req", 32'(req), 32'd1);
    addr_ok = 1;
    step();
    addr_ok = 0; data_ok = 1; rdata = 32'h0000_0002;
    @(negedge clk);
    chk("hold d_data_ok2", 32'(d_data_ok), 32'd1);
    chk("hold rd2", rd, 32'h0000_0002);
    step();
    data_ok = 0;
    @(negedge clk);
    chk("hold done busy", 32'(busy), 32'd0);
    step();

    // Reset while in DATA: abandoned, late data_ok ignored.
    ren = 1; addr = 32'h0000_0048;
    step();
    addr_ok = 1;
    step();
    addr_ok = 0; ren = 0; resetn = 0;
    @(negedge clk);
    chk("rd_rst data busy", 32'(busy), 32'd1);
    step();
    resetn = 1; data_ok = 1; rdata = 32'h0000_BEEF;
    @(negedge clk);
    chk("rd_rst busy", 32'(busy), 32'd0);
    chk("rd_rst req", 32'(req), 32'd0);
    chk("rd_rst d_data_ok", 32'(d_data_ok), 32'd0);
    chk("rd_rst baddr", baddr, 32'd0);
    step();
    data_ok = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
